// File: rtl/mem_line_bridge_pkg.sv
// Shared types for the memory-side line bridge: line/beat geometry, cache-facing
// request/response structs, narrow-bus structs and the bridge state encoding.
package mem_line_bridge_pkg;
    localparam int ADDR_W    = 32;
    localparam int LINE_W    = 128;
    localparam int BEAT_W    = 32;
    localparam int BEATS     = LINE_W / BEAT_W;
    localparam int OFF       = $clog2(LINE_W / 8);
    localparam int BEAT_BITS = $clog2(BEATS);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] data;
        logic              rw;
        logic              valid;
    } mem_req_type;

    typedef struct packed {
        logic [LINE_W-1:0] data;
        logic              valid;
    } mem_data_type;

    typedef struct packed {
        logic              valid;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [BEAT_W-1:0] wdata;
    } mem_bus_req_type;

    typedef struct packed {
        logic              rvalid;
        logic [BEAT_W-1:0] rdata;
    } mem_bus_rsp_type;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_R, DONE} bridge_state_type;
endpackage

// File: rtl/mem_line_bridge_if.sv
// Narrow valid/ready memory bus between the line bridge (master) and a memory slave.
interface mem_line_bridge_if;
    import mem_line_bridge_pkg::*;

    logic              bus_valid;
    logic              bus_ready;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [BEAT_W-1:0] bus_wdata;
    logic              bus_rvalid;
    logic [BEAT_W-1:0] bus_rdata;

    modport master (
        output bus_valid, bus_we, bus_addr, bus_wdata,
        input  bus_ready, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_valid, bus_we, bus_addr, bus_wdata,
        output bus_ready, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/mem_line_bridge.sv
// Serialises one cache line request into BEATS narrow bus transfers and returns the
// assembled (read) or echoed (write) line as a single-cycle mem_data pulse.
module mem_line_bridge
    import mem_line_bridge_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  mem_req_type              mem_req,
    output mem_data_type             mem_data,
    mem_line_bridge_if.master        bus,
    output logic                     busy
);
    bridge_state_type      state_q, state_d;
    logic [BEAT_BITS-1:0]  beat_q, beat_d;
    logic [ADDR_W-OFF-1:0] line_addr_q, line_addr_d;
    logic [LINE_W-1:0]     line_q, line_d;
    logic [LINE_W-1:0]     out_q, out_d;
    logic                  rw_q, rw_d;
    logic                  last_beat;
    mem_bus_req_type       breq;
    logic                  unused_addr_lsbs;

    assign unused_addr_lsbs = ^mem_req.addr[OFF-1:0];
    assign last_beat        = (beat_q == BEAT_BITS'(BEATS - 1));

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        line_addr_d = line_addr_q;
        line_d      = line_q;
        rw_d        = rw_q;
        out_d       = out_q;
        breq        = '0;
        unique case (state_q)
            // DONE must accept: the cache re-issues its allocate on write-back completion
            IDLE, DONE: begin
                state_d = IDLE;
                if (mem_req.valid) begin
                    state_d     = ISSUE;
                    beat_d      = '0;
                    line_addr_d = mem_req.addr[ADDR_W-1:OFF];
                    line_d      = mem_req.data;
                    rw_d        = mem_req.rw;
                end
            end
            ISSUE: begin
                breq.valid = 1'b1;
                breq.we    = rw_q;
                breq.addr  = {line_addr_q, beat_q, {(OFF-BEAT_BITS){1'b0}}};
                breq.wdata = line_q[int'(beat_q)*BEAT_W +: BEAT_W];
                if (bus.bus_ready) begin
                    if (!rw_q) begin
                        state_d = WAIT_R;
                    end else if (last_beat) begin
                        state_d = DONE;
                        out_d   = line_q;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            WAIT_R: begin
                if (bus.bus_rvalid) begin
                    line_d[int'(beat_q)*BEAT_W +: BEAT_W] = bus.bus_rdata;
                    if (last_beat) begin
                        state_d = DONE;
                        out_d   = line_d;
                    end else begin
                        state_d = ISSUE;
                        beat_d  = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            line_addr_q <= '0;
            line_q      <= '0;
            rw_q        <= 1'b0;
            out_q       <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            line_addr_q <= line_addr_d;
            line_q      <= line_d;
            rw_q        <= rw_d;
            out_q       <= out_d;
        end
    end

    // Bus outputs decode only from flops, so reset drops them without waiting for a clock
    assign bus.bus_valid = breq.valid;
    assign bus.bus_we    = breq.we;
    assign bus.bus_addr  = breq.addr;
    assign bus.bus_wdata = breq.wdata;
    assign mem_data.valid = (state_q == DONE);
    assign mem_data.data  = out_q;
    assign busy           = (state_q == ISSUE) || (state_q == WAIT_R);
endmodule

// File: tb/tb_mem_line_bridge.sv
// Directed scoreboard bench for mem_line_bridge: stimulus pushes expected beats/lines,
// a negedge monitor pops and compares whatever the bridge presents.
module tb_mem_line_bridge;
    import mem_line_bridge_pkg::*;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } beat_t;

    typedef struct {
        logic [127:0] data;
        int           edge_n;
    } line_t;

    logic         clk;
    logic         rst_n;
    mem_req_type  req;
    mem_data_type md;
    logic         busy;
    mem_line_bridge_if bif();

    mem_line_bridge dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mem_req  (req),
        .mem_data (md),
        .bus      (bif),
        .busy     (busy)
    );

    beat_t       exp_beats[$];
    line_t       exp_lines[$];
    logic [31:0] rd_q[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          rdelay = 1;
    int          stray_seq = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Slave: answers each accepted read beat rdelay cycles later; also injects stray rvalid
    initial begin
        int cnt = 0;
        int stray_seen = 0;
        logic [31:0] pend = '0;
        bif.bus_ready  = 1'b1;
        bif.bus_rvalid = 1'b0;
        bif.bus_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            bif.bus_rvalid = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    bif.bus_rvalid = 1'b1;
                    bif.bus_rdata  = pend;
                end
            end else if (stray_seen != stray_seq) begin
                stray_seen     = stray_seq;
                bif.bus_rvalid = 1'b1;
                bif.bus_rdata  = 32'h5A5A_5A5A;
            end
            @(negedge clk);
            if (rst_n && bif.bus_valid && bif.bus_ready && !bif.bus_we) begin
                cnt  = rdelay;
                pend = (rd_q.size() > 0) ? rd_q.pop_front() : 32'hBAD0_BAD0;
            end
        end
    end

    // Monitor: every presented beat must match the head beat; every pulse must match a line
    initial forever begin
        beat_t b;
        line_t l;
        @(negedge clk);
        if (rst_n) begin
            if (bif.bus_valid) begin
                if (exp_beats.size() == 0) begin
                    chk("beat_extra", 128'(exp_beats.size()), 128'd1);
                end else begin
                    b = exp_beats[0];
                    chk("beat_we", 128'(bif.bus_we), 128'(b.we));
                    chk("beat_addr", 128'(bif.bus_addr), 128'(b.addr));
                    if (b.we) chk("beat_wdata", 128'(bif.bus_wdata), 128'(b.wdata));
                    if (bif.bus_ready) void'(exp_beats.pop_front());
                end
            end
            if (md.valid) begin
                if (exp_lines.size() == 0) begin
                    chk("line_extra", 128'(exp_lines.size()), 128'd1);
                end else begin
                    l = exp_lines.pop_front();
                    chk("line_data", md.data, l.data);
                    chk("line_edge", 128'(cyc + 1), 128'(l.edge_n));
                end
            end
        end
    end

    // Raw one-cycle request pulse; call at posedge+#1, returns at the capture edge +#1
    task automatic pulse_req(input logic [31:0] addr, input logic [127:0] data, input logic rw);
        req.addr  = addr;
        req.data  = data;
        req.rw    = rw;
        req.valid = 1'b1;
        @(posedge clk);
        #1;
        req = '0;
    endtask

    task automatic send_req(input logic [31:0] addr, input logic [127:0] data, input logic rw,
                            input logic [127:0] exp_line, input int lat);
        beat_t b;
        line_t l;
        logic [127:0] tmp;
        for (int i = 0; i < 4; i++) begin
            b.we    = rw;
            b.addr  = {addr[31:4], 4'(i * 4)};
            tmp     = data >> (i * 32);
            b.wdata = tmp[31:0];
            exp_beats.push_back(b);
            if (!rw) begin
                tmp = exp_line >> (i * 32);
                rd_q.push_back(tmp[31:0]);
            end
        end
        l.data   = exp_line;
        l.edge_n = cyc + 1 + lat;
        exp_lines.push_back(l);
        pulse_req(addr, data, rw);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((exp_lines.size() != 0 || busy) && n < 80) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_drain"}, 128'(exp_lines.size()), 128'd0);
        chk({name, "_idle"}, 128'(busy), 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req   = '0;
        #1;
        chk("rst_bus_valid", 128'(bif.bus_valid), 128'd0);
        chk("rst_bus_we", 128'(bif.bus_we), 128'd0);
        chk("rst_bus_addr", 128'(bif.bus_addr), 128'd0);
        chk("rst_bus_wdata", 128'(bif.bus_wdata), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_md_valid", 128'(md.valid), 128'd0);
        chk("rst_md_data", md.data, 128'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: plain write, zero-wait
        send_req(32'h0000_1230, 128'h44443333_22221111_00000000_DEADBEEF, 1'b1,
                 128'h44443333_22221111_00000000_DEADBEEF, 5);
        wait_done("t1_write");

        // 2: read, slave answers A0..A3
        send_req(32'h0000_4008, 128'd0, 1'b0, 128'h000000A3_000000A2_000000A1_000000A0, 9);
        wait_done("t2_read");

        // 3: write with three ready-low cycles on beat 2
        send_req(32'h0000_2000, 128'h0F0E0D0C_0B0A0908_07060504_03020100, 1'b1,
                 128'h0F0E0D0C_0B0A0908_07060504_03020100, 8);
        repeat (2) @(posedge clk);
        #1 bif.bus_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 bif.bus_ready = 1'b1;
        wait_done("t3_stall");

        // 4: read request arrives in the DONE cycle of a write-back
        send_req(32'h0000_3010, 128'h11111111_22222222_33333333_44444444, 1'b1,
                 128'h11111111_22222222_33333333_44444444, 5);
        repeat (4) @(posedge clk);
        #1;
        chk("t4_in_done", 128'(md.valid), 128'd1);
        send_req(32'h0000_5000, 128'd0, 1'b0, 128'h00000088_00000077_00000066_00000055, 9);
        wait_done("t4_back2back");

        // 5: reset during WAIT_R of beat 1, late response after release
        send_req(32'h0000_6000, 128'd0, 1'b0, 128'h0, 9);
        @(posedge clk);
        #1 rdelay = 3;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t5_abort_valid", 128'(bif.bus_valid), 128'd0);
        chk("t5_abort_busy", 128'(busy), 128'd0);
        chk("t5_abort_md_valid", 128'(md.valid), 128'd0);
        chk("t5_abort_md_data", md.data, 128'd0);
        exp_beats.delete();
        exp_lines.delete();
        rd_q.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("t5_late_busy", 128'(busy), 128'd0);
        chk("t5_late_md_data", md.data, 128'd0);
        rdelay = 1;
        send_req(32'h0000_7004, 128'hCAFEF00D_01234567_89ABCDEF_76543210, 1'b1,
                 128'hCAFEF00D_01234567_89ABCDEF_76543210, 5);
        wait_done("t5_recover");

        // 6: stray rvalid in IDLE, then stray rvalid and a request while stalled in ISSUE
        stray_seq++;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_idle_busy", 128'(busy), 128'd0);
        chk("t6_idle_md_data", md.data, 128'hCAFEF00D_01234567_89ABCDEF_76543210);
        send_req(32'h0000_A000, 128'h99998888_77776666_55554444_33332222, 1'b1,
                 128'h99998888_77776666_55554444_33332222, 7);
        @(posedge clk);
        #1;
        bif.bus_ready = 1'b0;
        stray_seq++;
        pulse_req(32'h0000_9990, 128'hFFFF, 1'b0);
        @(posedge clk);
        #1 bif.bus_ready = 1'b1;
        wait_done("t6_busy_drop");
        repeat (3) @(posedge clk);
        #1;
        chk("t6_end_md_data", md.data, 128'h99998888_77776666_55554444_33332222);
        chk("t6_no_beats_left", 128'(exp_beats.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
